spritecache_multi: RTL and testbench

Parametrised successor to the single-hit sprite cache. Holds NUM_SPRITES sprite property records and answers, every cycle, "which sprites cover horizontal position hcursor". Each answer returns up to MAX_HITS matching records in ascending index order. Sits between the sprite-table loader (bus side) and the scanline pixel compositor (lookup side). Lookups are fully pipelined at a fixed 2-cycle latency; the bus port gives registered read-back and a defined stb/ack handshake.

---
 rtl/sprite_pkg.sv | 29 ++
 rtl/sc_hit_select.sv | 40 ++++
 rtl/spritecache_multi.sv | 189 ++++++++++++++++++
 tb/tb_spritecache_multi.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Sprite record layout and the coverage test shared by the sprite cache blocks.
package sprite_pkg;

  localparam int unsigned HPOS_W     = 10;
  localparam int unsigned SPRITE_W   = 64;
  localparam int unsigned HPOS_LSB   = 0;
  localparam int unsigned WIDTH_LSB  = HPOS_W;
  localparam int unsigned WIDTH_W    = 6;
  localparam int unsigned ENABLE_BIT = HPOS_W + WIDTH_W;
  localparam int unsigned SUM_W      = HPOS_W + 1;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_e;

  // Inclusive span hpos..hpos+width; the extra sum bit keeps the right edge from wrapping to 0.
  function automatic logic sprite_covers(input logic [SPRITE_W-1:0] rec,
                                         input logic [HPOS_W-1:0]   hc);
    logic [SUM_W-1:0] lo;
    logic [SUM_W-1:0] hi;
    logic [SUM_W-1:0] x;
    lo = {1'b0, rec[HPOS_LSB +: HPOS_W]};
    hi = lo + SUM_W'(rec[WIDTH_LSB +: WIDTH_W]);
    x  = {1'b0, hc};
    return rec[ENABLE_BIT] & (lo <= x) & (x <= hi);
  endfunction

endpackage

// File: rtl/sc_hit_select.sv
// Combinational first-N-of-M selector: picks the lowest-indexed MAX_HITS set bits of a match vector.
module sc_hit_select #(
  parameter int unsigned NUM_SPRITES = 32,
  parameter int unsigned MAX_HITS    = 4,
  parameter int unsigned IDX_W       = $clog2(NUM_SPRITES),
  parameter int unsigned CNT_W       = $clog2(MAX_HITS + 1)
) (
  input  logic [NUM_SPRITES-1:0]    i_match,
  output logic [MAX_HITS*IDX_W-1:0] o_idx_c,
  output logic [MAX_HITS-1:0]       o_slot_valid_c,
  output logic [CNT_W-1:0]          o_count_c,
  output logic                      o_overflow_c
);

  // Each slot claims the lowest remaining bit; whatever is left afterwards is overflow.
  always_comb begin : p_select
    logic [NUM_SPRITES-1:0] rem;
    logic                   found;
    rem            = i_match;
    found          = 1'b0;
    o_idx_c        = '0;
    o_slot_valid_c = '0;
    o_count_c      = '0;
    o_overflow_c   = 1'b0;
    for (int unsigned k = 0; k < MAX_HITS; k++) begin
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        if (!found && rem[i]) begin
          found                        = 1'b1;
          o_idx_c[k*IDX_W +: IDX_W]    = IDX_W'(i);
          rem[i]                       = 1'b0;
        end
      end
      o_slot_valid_c[k] = found;
      o_count_c         = o_count_c + CNT_W'(found);
    end
    o_overflow_c = |rem;
  end

endmodule

// File: rtl/spritecache_multi.sv
// Multi-hit sprite cache: 2-stage lookup pipeline returning up to MAX_HITS covering sprites,
// plus a stb/ack bus port for loading and reading back sprite records.
module spritecache_multi #(
  parameter int unsigned NUM_SPRITES = 32,
  parameter int unsigned MAX_HITS    = 4,
  parameter int unsigned HPOS_W      = sprite_pkg::HPOS_W,
  parameter int unsigned SPRITE_W    = sprite_pkg::SPRITE_W
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        lu_valid,
  input  logic [HPOS_W-1:0]                           lu_hcursor,
  output logic                                        res_valid,
  output logic [HPOS_W-1:0]                           res_hcursor,
  output logic [$clog2(MAX_HITS+1)-1:0]               res_count,
  output logic                                        res_overflow,
  output logic [MAX_HITS*$clog2(NUM_SPRITES)-1:0]     res_idx,
  output logic [MAX_HITS*SPRITE_W-1:0]                res_sprites,
  input  logic                                        stb,
  input  logic                                        wr,
  input  logic [$clog2(NUM_SPRITES)-1:0]              addr,
  input  logic [SPRITE_W-1:0]                         wr_sprite,
  output logic [SPRITE_W-1:0]                         rd_sprite,
  output logic                                        ack,
  input  logic                                        clear_all
);

  import sprite_pkg::*;

  localparam int unsigned IDX_W = $clog2(NUM_SPRITES);
  localparam int unsigned CNT_W = $clog2(MAX_HITS + 1);

  logic [SPRITE_W-1:0]       r_mem [NUM_SPRITES];
  logic [NUM_SPRITES-1:0]    r_valid;
  logic [SPRITE_W-1:0]       r_rd_sprite;
  bus_state_e                r_state;
  bus_state_e                w_state_nxt;
  logic                      w_start;
  logic                      w_wr_commit;
  logic                      w_rd_start;
  logic [NUM_SPRITES-1:0]    w_match;

  logic                      r_s1_valid;
  logic [HPOS_W-1:0]         r_s1_hc;
  logic [NUM_SPRITES-1:0]    r_s1_match;
  logic                      r_s1_wr;
  logic [IDX_W-1:0]          r_s1_wr_idx;
  logic [SPRITE_W-1:0]       r_s1_old;

  logic [MAX_HITS*IDX_W-1:0]    w_sel_idx;
  logic [MAX_HITS-1:0]          w_sel_slot_v;
  logic [CNT_W-1:0]             w_sel_count;
  logic                         w_sel_ovf;
  logic [MAX_HITS*SPRITE_W-1:0] w_slot_rec;

  logic                         r_res_valid;
  logic [HPOS_W-1:0]            r_res_hc;
  logic [CNT_W-1:0]             r_res_count;
  logic                         r_res_ovf;
  logic [MAX_HITS*IDX_W-1:0]    r_res_idx;
  logic [MAX_HITS*SPRITE_W-1:0] r_res_spr;

  // Bus FSM: state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= BUS_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Bus FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      BUS_IDLE: if (stb) w_state_nxt = BUS_ACK;
      BUS_ACK:  w_state_nxt = BUS_IDLE;
    endcase
  end

  // Bus FSM: transaction strobes; a request seen during reset is dropped
  always_comb begin
    w_start     = 1'b0;
    w_wr_commit = 1'b0;
    w_rd_start  = 1'b0;
    if (r_state == BUS_IDLE && stb && !reset) w_start = 1'b1;
    w_wr_commit = w_start & wr;
    w_rd_start  = w_start & ~wr;
  end

  assign ack       = (r_state == BUS_ACK);
  assign rd_sprite = r_rd_sprite;

  always_ff @(posedge clk) begin
    if (w_wr_commit) r_mem[addr] <= wr_sprite;
  end

  // Later NBA to the written bit wins over clear_all, leaving just that entry valid
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid     <= '0;
      r_rd_sprite <= '0;
    end else begin
      if (clear_all)   r_valid       <= '0;
      if (w_wr_commit) r_valid[addr] <= 1'b1;
      r_rd_sprite <= (w_rd_start && r_valid[addr]) ? r_mem[addr] : '0;
    end
  end

  always_comb begin
    w_match = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++)
      w_match[i] = r_valid[i] & sprite_covers(r_mem[i], lu_hcursor);
  end

  // S1 keeps the pre-write image of any entry written alongside the lookup, so S2 can
  // read the array late and still return the contents seen at S1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_hc     <= '0;
      r_s1_match  <= '0;
      r_s1_wr     <= 1'b0;
      r_s1_wr_idx <= '0;
      r_s1_old    <= '0;
    end else begin
      r_s1_valid <= lu_valid;
      if (lu_valid) begin
        r_s1_hc     <= lu_hcursor;
        r_s1_match  <= w_match;
        r_s1_wr     <= w_wr_commit;
        r_s1_wr_idx <= addr;
        r_s1_old    <= r_mem[addr];
      end
    end
  end

  sc_hit_select #(
    .NUM_SPRITES (NUM_SPRITES),
    .MAX_HITS    (MAX_HITS),
    .IDX_W       (IDX_W),
    .CNT_W       (CNT_W)
  ) u_hit_select (
    .i_match        (r_s1_match),
    .o_idx_c        (w_sel_idx),
    .o_slot_valid_c (w_sel_slot_v),
    .o_count_c      (w_sel_count),
    .o_overflow_c   (w_sel_ovf)
  );

  always_comb begin : p_slot_rec
    logic [IDX_W-1:0] idx;
    idx        = '0;
    w_slot_rec = '0;
    for (int unsigned k = 0; k < MAX_HITS; k++) begin
      idx = w_sel_idx[k*IDX_W +: IDX_W];
      if (w_sel_slot_v[k]) begin
        if (r_s1_wr && idx == r_s1_wr_idx) w_slot_rec[k*SPRITE_W +: SPRITE_W] = r_s1_old;
        else                               w_slot_rec[k*SPRITE_W +: SPRITE_W] = r_mem[idx];
      end
    end
  end

  // S2: results only move when a lookup completes, otherwise they hold
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res_valid <= 1'b0;
      r_res_hc    <= '0;
      r_res_count <= '0;
      r_res_ovf   <= 1'b0;
      r_res_idx   <= '0;
      r_res_spr   <= '0;
    end else begin
      r_res_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_res_hc    <= r_s1_hc;
        r_res_count <= w_sel_count;
        r_res_ovf   <= w_sel_ovf;
        r_res_idx   <= w_sel_idx;
        r_res_spr   <= w_slot_rec;
      end
    end
  end

  assign res_valid    = r_res_valid;
  assign res_hcursor  = r_res_hc;
  assign res_count    = r_res_count;
  assign res_overflow = r_res_ovf;
  assign res_idx      = r_res_idx;
  assign res_sprites  = r_res_spr;

endmodule

// File: tb/tb_spritecache_multi.sv
// Scoreboard bench for spritecache_multi: a plain array model predicts lookup and bus
// responses at issue time; a negedge monitor pops and compares them against the DUT.
module tb_spritecache_multi;

  localparam int NS = 32;
  localparam int MH = 4;
  localparam int HW = 10;
  localparam int SW = 64;
  localparam int IW = 5;
  localparam int CW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              lu_valid;
  logic [HW-1:0]     lu_hcursor;
  logic              res_valid;
  logic [HW-1:0]     res_hcursor;
  logic [CW-1:0]     res_count;
  logic              res_overflow;
  logic [MH*IW-1:0]  res_idx;
  logic [MH*SW-1:0]  res_sprites;
  logic              stb;
  logic              wr;
  logic [IW-1:0]     addr;
  logic [SW-1:0]     wr_sprite;
  logic [SW-1:0]     rd_sprite;
  logic              ack;
  logic              clear_all;

  spritecache_multi #(.NUM_SPRITES(NS), .MAX_HITS(MH), .HPOS_W(HW), .SPRITE_W(SW)) dut (
    .clk          (clk),
    .reset        (reset),
    .lu_valid     (lu_valid),
    .lu_hcursor   (lu_hcursor),
    .res_valid    (res_valid),
    .res_hcursor  (res_hcursor),
    .res_count    (res_count),
    .res_overflow (res_overflow),
    .res_idx      (res_idx),
    .res_sprites  (res_sprites),
    .stb          (stb),
    .wr           (wr),
    .addr         (addr),
    .wr_sprite    (wr_sprite),
    .rd_sprite    (rd_sprite),
    .ack          (ack),
    .clear_all    (clear_all)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               tag;
    int               hc;
    int               cnt;
    bit               ovf;
    logic [MH*IW-1:0] idx;
    logic [MH*SW-1:0] spr;
  } lu_exp_t;

  typedef struct {
    int          tag;
    logic [SW-1:0] data;
  } bus_exp_t;

  lu_exp_t       luq[$];
  bus_exp_t      bq[$];
  logic [SW-1:0] m_mem [NS];
  bit            m_valid [NS];
  bit            m_busy = 1'b0;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  bit rst_d = 1'b0;

  int               last_cnt = 0;
  bit               last_ovf = 1'b0;
  int               last_hc = 0;
  logic [MH*IW-1:0] last_idx = '0;
  logic [MH*SW-1:0] last_spr = '0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_d <= reset;
  end

  task automatic chk(input string nm, input logic [MH*SW-1:0] act, input logic [MH*SW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Record: hpos [9:0], width [15:10], enable [16], payload above
  function automatic logic [SW-1:0] mk(input int hp, input int wd, input bit en);
    logic [46:0] pl;
    pl = 47'({$urandom(), $urandom()});
    return {pl, en, 6'(wd), 10'(hp)};
  endfunction

  function automatic lu_exp_t model_lookup(input int hc);
    lu_exp_t e;
    int      hits[$];
    int      hp;
    int      wd;
    e.tag = 0; e.hc = hc; e.idx = '0; e.spr = '0;
    for (int i = 0; i < NS; i++) begin
      hp = int'(m_mem[i][9:0]);
      wd = int'(m_mem[i][15:10]);
      if (m_valid[i] && m_mem[i][16] && hp <= hc && hc <= hp + wd) hits.push_back(i);
    end
    e.ovf = hits.size() > MH;
    e.cnt = e.ovf ? MH : hits.size();
    for (int k = 0; k < e.cnt; k++) begin
      e.idx[k*IW +: IW] = IW'(hits[k]);
      e.spr[k*SW +: SW] = m_mem[hits[k]];
    end
    return e;
  endfunction

  // One clock of stimulus; lookups see the model before this cycle's write lands
  task automatic step(input bit lv, input int hc, input bit s, input bit w, input int a,
                      input logic [SW-1:0] d, input bit clr, input bit rst);
    lu_exp_t  e;
    bus_exp_t b;
    bit       start;
    lu_valid = lv; lu_hcursor = 10'(hc); stb = s; wr = w; addr = 5'(a);
    wr_sprite = d; clear_all = clr; reset = rst;
    if (rst) begin
      while (luq.size() > 0 && luq[$].tag > cyc) void'(luq.pop_back());
      while (bq.size() > 0 && bq[$].tag > cyc) void'(bq.pop_back());
      for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
      m_busy = 1'b0;
    end else begin
      if (lv) begin
        e = model_lookup(hc);
        e.tag = cyc + 2;
        luq.push_back(e);
      end
      start = s && !m_busy;
      if (start) begin
        b.tag  = cyc + 1;
        b.data = (!w && m_valid[a]) ? m_mem[a] : '0;
        bq.push_back(b);
        if (w) m_mem[a] = d;
      end
      if (clr) for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
      if (start && w) m_valid[a] = 1'b1;
      m_busy = start;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic lookup(input int hc);
    step(1, hc, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic wr_entry(input int a, input logic [SW-1:0] d);
    step(0, 0, 1, 1, a, d, 0, 0);
    idle(1);
  endtask

  task automatic rd_entry(input int a);
    step(0, 0, 1, 0, a, '0, 0, 0);
    idle(1);
  endtask

  always @(negedge clk) begin : monitor
    lu_exp_t  e;
    bit       ev;
    bit       eb;
    if (mon_en) begin
      if (rst_d) begin
        last_cnt = 0; last_ovf = 1'b0; last_hc = 0; last_idx = '0; last_spr = '0;
      end
      while (luq.size() > 0 && luq[0].tag < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL lookup_missing cyc=%0d actual=no_result required=result_at_%0d", cyc, luq[0].tag);
        void'(luq.pop_front());
      end
      ev = (luq.size() > 0) && (luq[0].tag == cyc);
      chk("res_valid", res_valid, ev);
      if (ev) begin
        e = luq.pop_front();
        chk("res_hcursor", res_hcursor, e.hc);
        chk("res_count", res_count, e.cnt);
        chk("res_overflow", res_overflow, e.ovf);
        chk("res_idx", res_idx, e.idx);
        chk("res_sprites", res_sprites, e.spr);
        last_cnt = e.cnt; last_ovf = e.ovf; last_hc = e.hc; last_idx = e.idx; last_spr = e.spr;
      end else begin
        chk("hold_count", res_count, last_cnt);
        chk("hold_overflow", res_overflow, last_ovf);
        chk("hold_hcursor", res_hcursor, last_hc);
        chk("hold_idx", res_idx, last_idx);
        chk("hold_sprites", res_sprites, last_spr);
      end
      while (bq.size() > 0 && bq[0].tag < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL ack_missing cyc=%0d actual=no_ack required=ack_at_%0d", cyc, bq[0].tag);
        void'(bq.pop_front());
      end
      eb = (bq.size() > 0) && (bq[0].tag == cyc);
      chk("ack", ack, eb);
      chk("rd_sprite", rd_sprite, eb ? bq[0].data : '0);
      if (eb) void'(bq.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

  initial begin
    int ents[6];
    logic [SW-1:0] d;
    ents = '{1, 3, 4, 6, 7, 9};
    for (int i = 0; i < NS; i++) begin m_mem[i] = '0; m_valid[i] = 1'b0; end
    reset = 1'b1; lu_valid = 1'b0; lu_hcursor = '0; stb = 1'b0; wr = 1'b0;
    addr = '0; wr_sprite = '0; clear_all = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Single entry edges
    wr_entry(0, mk(100, 16, 1));
    lookup(99); lookup(100); lookup(116); lookup(117);
    idle(3);

    // Overflow and ascending order, then disable entry 3
    foreach (ents[j]) wr_entry(ents[j], mk(190 + ents[j], 20, 1));
    lookup(200);
    wr_entry(3, mk(193, 20, 0));
    lookup(200);
    idle(3);

    // No wrap past the right edge; zero width covers one pixel
    wr_entry(5, mk(1020, 10, 1));
    lookup(1023);
    for (int x = 0; x < 10; x++) lookup(x);
    wr_entry(10, mk(50, 0, 1));
    lookup(49); lookup(50); lookup(51);
    idle(3);

    // Write during a lookup stream, then read it back
    d = mk(300, 5, 1);
    step(1, 300, 1, 1, 2, d, 0, 0);
    lookup(300); lookup(302);
    idle(3);
    rd_entry(2);

    // clear_all together with a write
    step(0, 0, 1, 1, 8, mk(195, 10, 1), 1, 0);
    idle(1);
    lookup(200); lookup(100); lookup(300);
    rd_entry(0);
    idle(3);

    // Random traffic
    for (int t = 0; t < 400; t++) begin
      int hc;
      int hp;
      hc = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(480, 650));
      hp = ($urandom_range(0, 9) == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(480, 620));
      step($urandom_range(0, 9) < 7, hc, $urandom_range(0, 2) == 0, $urandom_range(0, 2) != 0,
           int'($urandom_range(0, NS - 1)),
           mk(hp, int'($urandom_range(0, 63)), $urandom_range(0, 5) != 0),
           $urandom_range(0, 59) == 0, 0);
    end
    idle(3);

    // Reset with lookups in flight and stb held
    foreach (ents[j]) wr_entry(ents[j], mk(190 + ents[j], 20, 1));
    lookup(200); lookup(200);
    step(1, 200, 1, 1, 11, mk(200, 3, 1), 0, 1);
    step(1, 200, 1, 0, 1, '0, 0, 1);
    idle(1);
    lookup(200); lookup(100); lookup(1023);
    for (int t = 0; t < 8; t++) lookup(int'($urandom_range(0, 1023)));
    idle(4);

    chk("drain", luq.size() + bq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
